// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [3:0] TIMEOUT_CYCLES = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - byte-lane steering for data-memory requests and load data
module byte_lane_unit
  import mem_stage_pkg::*;
(
  input  logic              byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rd_byte_i,
  input  logic [1:0]        rd_lane_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] load_data_o
);

  always_comb begin
    mem_addr_o = {addr_i[ADDR_W-1:2], 2'b00};
    be_o       = byte_i ? (4'b0001 << addr_i[1:0]) : 4'hF;
    wdata_o    = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
  end

  // Byte loads are zero-extended from the lane selected by the latched address.
  always_comb begin
    load_data_o = rdata_i;
    if (rd_byte_i) begin
      case (rd_lane_i)
        2'd0:    load_data_o = {24'b0, rdata_i[7:0]};
        2'd1:    load_data_o = {24'b0, rdata_i[15:8]};
        2'd2:    load_data_o = {24'b0, rdata_i[23:16]};
        default: load_data_o = {24'b0, rdata_i[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake FSM, stall and status
module mem_access_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              RegWriteM,
  input  logic              PCSrcM,
  input  logic              ByteM,
  input  logic [3:0]        WA3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              MemtoRegOut,
  output logic              RegWriteOut,
  output logic              PCSrcOut,
  output logic [3:0]        WA3Out,
  output logic [ADDR_W-1:0] ALUResultOut,
  output logic [DATA_W-1:0] RDataM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              MisalignM,
  output logic              MemErrM
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;

  logic              pending;
  logic              misaligned;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] load_data;

  byte_lane_unit u_lanes (
    .byte_i      (ByteM),
    .addr_i      (ALUResultM),
    .wdata_i     (WriteDataM),
    .mem_addr_o  (req_addr),
    .be_o        (req_be),
    .wdata_o     (req_wdata),
    .rd_byte_i   (byte_q),
    .rd_lane_i   (lane_q),
    .rdata_i     (mem_rdata),
    .load_data_o (load_data)
  );

  assign pending    = MemtoRegM | MemWriteM;
  assign misaligned = !ByteM && (ALUResultM[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    byte_d     = byte_q;
    lane_d     = lane_q;
    misalign_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          if (misaligned) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'd0;
            addr_d  = req_addr;
            be_d    = req_be;
            wdata_d = req_wdata;
            we_d    = MemWriteM;
            byte_d  = ByteM;
            lane_d  = ALUResultM[1:0];
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = load_data;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= '0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      lane_q     <= 2'd0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      byte_q     <= byte_d;
      lane_q     <= lane_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  assign MemtoRegOut  = MemtoRegM;
  assign RegWriteOut  = RegWriteM;
  assign PCSrcOut     = PCSrcM;
  assign WA3Out       = WA3M;
  assign ALUResultOut = ALUResultM;

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign RDataM    = rdata_q;
  assign MisalignM = misalign_q;
  assign MemErrM   = err_q;
  assign StallM    = ((state_q == IDLE) && pending) || (state_q == BUSY);

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench with a transaction-level model
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoRegM, MemWriteM, RegWriteM, PCSrcM, ByteM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemtoRegOut, RegWriteOut, PCSrcOut;
  logic [3:0]  WA3Out;
  logic [31:0] ALUResultOut, RDataM;
  logic        StallM, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready, MisalignM, MemErrM;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .PCSrcM(PCSrcM), .ByteM(ByteM), .WA3M(WA3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .PCSrcOut(PCSrcOut),
    .WA3Out(WA3Out), .ALUResultOut(ALUResultOut), .RDataM(RDataM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .MisalignM(MisalignM), .MemErrM(MemErrM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        check_en = 1'b0;
  logic        exp_stall, exp_req, exp_misal, exp_we, exp_reset_regs;
  logic [31:0] exp_addr, exp_wdata, rdata_exp;
  logic [3:0]  exp_be;
  logic        err_exp;
  int          stall_cnt;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (StallM === 1'b1) stall_cnt++;
    if (mem_req === 1'b1) begin
      last_addr  = mem_addr;
      last_be    = mem_be;
      last_wdata = mem_wdata;
      last_we    = mem_we;
    end
    if (check_en) begin
      chk("stall", {31'b0, StallM}, {31'b0, exp_stall});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      chk("misalign", {31'b0, MisalignM}, {31'b0, exp_misal});
      chk("memerr", {31'b0, MemErrM}, {31'b0, err_exp});
      chk("rdata", RDataM, rdata_exp);
      chk("passthru_ctrl", {25'b0, MemtoRegOut, RegWriteOut, PCSrcOut, WA3Out},
          {25'b0, MemtoRegM, RegWriteM, PCSrcM, WA3M});
      chk("passthru_alu", ALUResultOut, ALUResultM);
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      end
      if (exp_reset_regs) begin
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
      end
    end
  end

  task automatic drive_idle_inputs();
    MemtoRegM  = 1'b0;
    MemWriteM  = 1'b0;
    RegWriteM  = 1'($urandom);
    PCSrcM     = 1'($urandom);
    ByteM      = 1'($urandom);
    WA3M       = 4'($urandom);
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle_inputs();
      exp_stall = 1'b0;
      exp_req   = 1'b0;
      exp_misal = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    check_en = 1'b0;
    rst = 1'b0;
    drive_idle_inputs();
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle_inputs();
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle_inputs();
    rdata_exp      = 32'h0;
    err_exp        = 1'b0;
    exp_stall      = 1'b0;
    exp_req        = 1'b0;
    exp_misal      = 1'b0;
    exp_reset_regs = 1'b1;
    check_en       = 1'b1;
  endtask

  // One access as seen by the pipeline: cycle 0 presents it, cycles 1..b are the
  // bus transfer, cycle b+1 is the result cycle; abort_at stops early for reset.
  task automatic run_txn(input logic ld, input logic st, input logic bt,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input int abort_at, output int stalls);
    logic misal, tmo, busy, rw, pcs;
    logic [3:0] wa;
    int b;
    misal = !bt && (a[1:0] != 2'b00);
    tmo   = !misal && (waits > 15);
    b     = misal ? 0 : (tmo ? 16 : waits + 1);
    rw    = 1'($urandom);
    pcs   = 1'($urandom);
    wa    = 4'($urandom);
    stalls = 0;
    for (int k = 0; k <= b + 1; k++) begin
      if (abort_at != 0 && k == abort_at) return;
      @(posedge clk); #1;
      MemtoRegM  = ld;
      MemWriteM  = st;
      RegWriteM  = rw;
      PCSrcM     = pcs;
      ByteM      = bt;
      WA3M       = wa;
      ALUResultM = a;
      WriteDataM = wd;
      if (k == 0) stall_cnt = 0;
      busy      = (k >= 1) && (k <= b);
      mem_ready = busy ? (!tmo && (k - 1 == waits)) : 1'($urandom);
      mem_rdata = busy ? rd : $urandom;
      exp_stall = (k <= b);
      exp_req   = busy;
      exp_misal = misal && (k == b + 1);
      exp_reset_regs = 1'b0;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_be    = bt ? (4'b0001 << a[1:0]) : 4'hF;
      exp_wdata = bt ? {4{wd[7:0]}} : wd;
      exp_we    = st;
      if (k == b + 1) begin
        if (misal || tmo) rdata_exp = 32'h0;
        else if (!st) rdata_exp = bt ? ((rd >> (8 * a[1:0])) & 32'hFF) : rd;
        if (tmo) err_exp = 1'b1;
      end
    end
    @(negedge clk); #1;
    stalls = stall_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic ld, st, bt;
    logic [31:0] a;
    int waits, r, kind;
    rst = 1'b0;
    drive_idle_inputs();
    exp_reset_regs = 1'b0;
    rdata_exp = 32'h0;
    err_exp = 1'b0;
    stall_cnt = 0;
    do_reset(2);
    idle_cycles(2);

    run_txn(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, s);
    chk("r026_stall_cycles", s, 32'd2);
    chk("r026_be", {28'b0, last_be}, 32'hF);
    chk("r026_rdata", RDataM, 32'hDEADBEEF);

    run_txn(0, 1, 1, 32'h203, 32'h12345678, 32'h55AA55AA, 0, 0, s);
    chk("r027_addr", last_addr, 32'h200);
    chk("r027_be", {28'b0, last_be}, 32'h8);
    chk("r027_wdata", last_wdata, 32'h78787878);
    chk("r027_we", {31'b0, last_we}, 32'h1);
    chk("r027_rdata_kept", RDataM, 32'hDEADBEEF);

    run_txn(1, 0, 1, 32'h2, 32'h0, 32'hAABBCCDD, 3, 0, s);
    chk("r028_stall_cycles", s, 32'd5);
    chk("r028_rdata", RDataM, 32'h000000BB);

    run_txn(1, 0, 0, 32'h6, 32'h0, 32'h11111111, 0, 0, s);
    chk("r029_stall_cycles", s, 32'd1);
    chk("r029_rdata", RDataM, 32'h0);
    idle_cycles(2);

    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h22222222, 99, 0, s);
    chk("r030_stall_cycles", s, 32'd17);
    chk("r030_err", {31'b0, MemErrM}, 32'h1);
    chk("r030_rdata", RDataM, 32'h0);
    idle_cycles(3);
    do_reset(1);
    idle_cycles(1);
    chk("r030_err_cleared", {31'b0, MemErrM}, 32'h0);

    run_txn(1, 0, 0, 32'h80, 32'h0, 32'h33333333, 10, 0, s);
    run_txn(1, 0, 0, 32'h84, 32'h0, 32'h44444444, 10, 2, s);
    do_reset(1);
    idle_cycles(4);
    chk("r031_req", {31'b0, mem_req}, 32'h0);
    chk("r031_rdata", RDataM, 32'h0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom % 20;
      if (r == 0) begin
        do_reset(1 + $urandom % 2);
      end else if (r < 4) begin
        idle_cycles(1 + $urandom % 3);
      end else begin
        kind = $urandom % 3;
        ld = (kind != 1);
        st = (kind != 0);
        bt = 1'($urandom);
        a  = $urandom;
        if (!bt && ($urandom % 5 != 0)) a[1:0] = 2'b00;
        waits = ($urandom % 8 == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
        run_txn(ld, st, bt, a, $urandom, $urandom, waits, 0, s);
      end
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
